// File: rtl/hex_frame_collector.sv
// Frames "<cmd><CHAR_NUM chars><CR|LF>" from a UART byte stream into a command byte and packed ASCII payload.
// Optional inter-character timeout is compiled in with `define HEX_FRAME_TIMEOUT_EN.
module hex_frame_collector #(
    parameter int CHAR_NUM    = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  iRX_VALID,
    input  logic [7:0]            iRX_DATA,
    output logic [7:0]            oCMD,
    output logic [CHAR_NUM*8-1:0] oASCII,
    output logic                  oVALID,
    output logic                  oLEN_ERR,
    output logic                  oBUSY
);

    localparam int SREG_W = CHAR_NUM * 8;
    localparam int CNT_W  = $clog2(CHAR_NUM + 1);

    typedef enum logic [1:0] {IDLE, DATA, OVF} state_t;
    typedef enum logic [1:0] {CLS_TERM, CLS_SPACE, CLS_PRINT, CLS_ILLEGAL} byte_cls_t;

    state_t            state, next_state;
    byte_cls_t         byte_cls;
    logic [7:0]        cmd_stage;
    logic [SREG_W-1:0] sreg;
    logic [CNT_W-1:0]  count;
    logic              count_full;
    logic              timeout;
    logic              load_cmd, shift_in, accept, reject;

    assign count_full = (count == CNT_W'(CHAR_NUM));

    // NOTE: every signal assigned in an always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        byte_cls = CLS_ILLEGAL;
        if (iRX_DATA == 8'h0D || iRX_DATA == 8'h0A)
            byte_cls = CLS_TERM;
        else if (iRX_DATA == 8'h20)
            byte_cls = CLS_SPACE;
        else if (iRX_DATA >= 8'h21 && iRX_DATA <= 8'h7E)
            byte_cls = CLS_PRINT;
    end

`ifdef HEX_FRAME_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [IDLE_W-1:0] idle_cnt;

    // A byte in the timeout cycle wins: it is processed and restarts the count.
    assign timeout = (state != IDLE) && !iRX_VALID && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            idle_cnt <= '0;
        else if (iRX_VALID || state == IDLE || timeout)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + IDLE_W'(1);
    end
`else
    // Without the timeout a frame waits for its terminator forever; TIMEOUT_CYC is inert here.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (iRX_VALID) begin
            case (state)
                IDLE: if (byte_cls == CLS_PRINT) next_state = DATA;
                DATA: begin
                    case (byte_cls)
                        CLS_PRINT:   if (count_full) next_state = OVF;
                        CLS_TERM:    next_state = IDLE;
                        CLS_ILLEGAL: next_state = OVF;
                        default:     next_state = DATA;
                    endcase
                end
                OVF:  if (byte_cls == CLS_TERM) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end else if (timeout) begin
            next_state = IDLE;
        end
    end

    always_comb begin
        load_cmd = 1'b0;
        shift_in = 1'b0;
        accept   = 1'b0;
        reject   = 1'b0;
        if (iRX_VALID) begin
            case (state)
                IDLE: load_cmd = (byte_cls == CLS_PRINT);
                DATA: begin
                    shift_in = (byte_cls == CLS_PRINT) && !count_full;
                    accept   = (byte_cls == CLS_TERM) && count_full;
                    reject   = (byte_cls == CLS_TERM) && !count_full;
                end
                OVF:  reject = (byte_cls == CLS_TERM);
                default: reject = 1'b0;
            endcase
        end else begin
            reject = timeout;
        end
    end

    // NOTE: staging registers are reset too, so a reset mid-frame leaves no stale payload behind.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cmd_stage <= '0;
            sreg      <= '0;
            count     <= '0;
            oCMD      <= '0;
            oASCII    <= '0;
            oVALID    <= 1'b0;
            oLEN_ERR  <= 1'b0;
            oBUSY     <= 1'b0;
        end else begin
            oVALID   <= accept;
            oLEN_ERR <= reject;
            oBUSY    <= (next_state != IDLE);
            if (load_cmd) begin
                cmd_stage <= iRX_DATA;
                count     <= '0;
            end
            // The cast keeps the low SREG_W bits, i.e. drops the oldest char off the top.
            if (shift_in) begin
                sreg  <= SREG_W'({sreg, iRX_DATA});
                count <= count + CNT_W'(1);
            end
            if (accept) begin
                oCMD   <= cmd_stage;
                oASCII <= sreg;
            end
        end
    end

endmodule

// File: tb/tb_hex_frame_collector.sv
// Self-checking bench for hex_frame_collector: text-level frame model checked every cycle plus directed literals.
// The timeout scenario runs only when HEX_FRAME_TIMEOUT_EN is defined.
module tb_hex_frame_collector;

    localparam int CHAR_NUM    = 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int W           = CHAR_NUM * 8;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_data  = 8'h00;
    logic [7:0]   cmd;
    logic [W-1:0] ascii;
    logic         valid, len_err, busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hex_frame_collector #(
        .CHAR_NUM   (CHAR_NUM),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .iRX_VALID(rx_valid),
        .iRX_DATA (rx_data),
        .oCMD     (cmd),
        .oASCII   (ascii),
        .oVALID   (valid),
        .oLEN_ERR (len_err),
        .oBUSY    (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: a frame starts at the first printable byte, spaces vanish, and it is
    // good only if exactly CHAR_NUM printable chars and nothing illegal precede the terminator.
    logic [7:0]   q[$];
    bit           m_started, m_bad;
    logic [7:0]   m_cmd;
    logic [7:0]   exp_cmd;
    logic [W-1:0] exp_ascii;
    bit           exp_valid, exp_err, exp_busy;
    longint       cyc, last_cyc;

    function automatic logic [W-1:0] pack_payload();
        logic [W-1:0] a = '0;
        foreach (q[i]) a = (a << 8) | W'(q[i]);
        return a;
    endfunction

    task model_byte(input logic [7:0] b);
        if (b == 8'h20) begin
            // spaces never count
        end else if (b == 8'h0D || b == 8'h0A) begin
            if (m_started) begin
                if (!m_bad && q.size() == CHAR_NUM) begin
                    exp_valid = 1'b1;
                    exp_cmd   = m_cmd;
                    exp_ascii = pack_payload();
                end else begin
                    exp_err = 1'b1;
                end
                m_started = 1'b0;
            end
        end else if (b >= 8'h21 && b <= 8'h7E) begin
            if (!m_started) begin
                m_started = 1'b1;
                m_bad     = 1'b0;
                m_cmd     = b;
                q.delete();
            end else begin
                q.push_back(b);
            end
        end else if (m_started) begin
            m_bad = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_started = 1'b0;
            m_bad     = 1'b0;
            m_cmd     = 8'h00;
            exp_cmd   = 8'h00;
            exp_ascii = '0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            exp_busy  = 1'b0;
            cyc       = 0;
            last_cyc  = 0;
        end else begin
            cyc++;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            if (rx_valid) begin
                last_cyc = cyc;
                model_byte(rx_data);
            end
`ifdef HEX_FRAME_TIMEOUT_EN
            else if (m_started && (cyc - last_cyc) == TIMEOUT_CYC) begin
                exp_err   = 1'b1;
                m_started = 1'b0;
            end
`endif
            exp_busy = m_started;
        end
    end

    always @(negedge clk) begin
        check("cmd",     cmd,     exp_cmd);
        check("ascii",   ascii,   exp_ascii);
        check("valid",   valid,   exp_valid);
        check("len_err", len_err, exp_err);
        check("busy",    busy,    exp_busy);
    end

    int n_valid = 0;
    int n_err   = 0;
    always @(negedge clk) begin
        if (valid)   n_valid++;
        if (len_err) n_err++;
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulses observed after a sequence: exact counts prove single-cycle pulses and no spurious ones.
    int v0, e0;
    task automatic expect_pulses(input string name, input int dv, input int de);
        idle(2);
        check({name, "_valid_pulses"}, n_valid - v0, dv);
        check({name, "_err_pulses"},   n_err - e0,   de);
    endtask

    task automatic mark();
        v0 = n_valid;
        e0 = n_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd",   cmd,     8'h00);
        check("reset_ascii", ascii,   16'h0000);
        check("reset_valid", valid,   1'b0);
        check("reset_err",   len_err, 1'b0);
        check("reset_busy",  busy,    1'b0);
        rst_n = 1'b1;
        idle(2);

        mark(); send_str("W3F\r");
        expect_pulses("w3f", 1, 0);
        check("w3f_cmd",   cmd,   8'h57);
        check("w3f_ascii", ascii, 16'h3346);

        mark(); send_str("\r\nW3F\r\n");
        expect_pulses("crlf", 1, 0);

        mark(); send_str("W3\r");
        expect_pulses("short", 0, 1);
        check("short_cmd_hold",   cmd,   8'h57);
        check("short_ascii_hold", ascii, 16'h3346);

        mark(); send_str("WABC\r");
        expect_pulses("ovf", 0, 1);

        mark(); send_str("R 1 2\n");
        expect_pulses("spaces", 1, 0);
        check("spaces_cmd",   cmd,   8'h52);
        check("spaces_ascii", ascii, 16'h3132);

        mark(); send(8'h57); send(8'h01); send_str("3F\r");
        expect_pulses("illegal_data", 0, 1);

        mark(); send(8'h80); send(8'h00); send_str("K45\r");
        expect_pulses("illegal_idle", 1, 0);
        check("illegal_idle_cmd",   cmd,   8'h4B);
        check("illegal_idle_ascii", ascii, 16'h3435);

        mark(); send_str("W\r");
        expect_pulses("empty", 0, 1);

        mark(); send_str("Z123 4\r");
        expect_pulses("ovf_space", 0, 1);

        mark(); send_str("W3");
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cmd",   cmd,     8'h00);
        check("midrst_ascii", ascii,   16'h0000);
        check("midrst_valid", valid,   1'b0);
        check("midrst_err",   len_err, 1'b0);
        check("midrst_busy",  busy,    1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        expect_pulses("midrst", 0, 0);

        mark(); send_str("W00\r");
        expect_pulses("after_rst", 1, 0);
        check("after_rst_cmd",   cmd,   8'h57);
        check("after_rst_ascii", ascii, 16'h3030);

`ifdef HEX_FRAME_TIMEOUT_EN
        begin
            int k;
            send(8'h57);
            @(negedge clk);
            check("to_busy_start", busy, 1'b1);
            k = 2;
            while (k <= 40 && !len_err) begin
                @(negedge clk);
                if (!len_err) k++;
            end
            check("to_latency", k - 1, TIMEOUT_CYC);
            @(negedge clk);
            check("to_busy_end", busy, 1'b0);
        end
`endif

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
